hamming_encoder_11_7_stream: RTL
================================

// Module: hamming_encoder_11_7_stream
// PURPOSE
//  Streaming Hamming(11,7) encoder with a valid/ready handshake on both sides and an output FIFO.
//  Transmit-side counterpart of the 11/7 decoder: produces the exact codeword bit layout the decoder expects.
//  Optional single-bit error injection drives the decoder's correction path in system test.
// PARAMETERS
//  DEPTH  4   output FIFO entries; power of 2, >=2
//  CNT_W  16  width of accepted-word counter
// PORTS
//  clk           in   1                 clock, all logic on posedge
//  sreset        in   1                 synchronous reset, active-high
//  in_valid      in   1                 input word valid
//  in_ready      out  1                 encoder can accept a word
//  in_data       in   7                 data word d[6:0]
//  inj_en        in   1                 flip one codeword bit of this word (sampled with in_data)
//  inj_pos       in   4                 1-based bit position to flip, legal 1..11
//  out_valid     out  1                 FIFO head valid
//  out_ready     in   1                 downstream accepts head
//  out_code      out  11                codeword c[10:0]
//  out_injected  out  1                 head word carries an injected error
//  level         out  $clog2(DEPTH)+1   FIFO occupancy
//  word_cnt      out  CNT_W             count of accepted input words
//  inj_err       out  1                 sticky: inj_en seen with an illegal inj_pos
// BEHAVIOUR
//  Layout: c[2]=d0 c[4]=d1 c[5]=d2 c[6]=d3 c[8]=d4 c[9]=d5 c[10]=d6.
//   c[0]=d0^d1^d3^d4^d6  c[1]=d0^d2^d3^d5^d6  c[3]=d1^d2^d3  c[7]=d4^d5^d6.
//  Push when in_valid&&in_ready. The codeword is computed combinationally and written to FIFO[wr_ptr] in that cycle.
//  Injection: if inj_en and inj_pos in 1..11, invert c[inj_pos-1] and store injected=1.
//   If inj_en with inj_pos 0 or 12..15: no flip, injected=0, inj_err<=1; inj_err is cleared only by sreset.
//  in_ready = !sreset && (level != DEPTH). Registered-state only; no combinational path from out_ready.
//  out_valid = (level != 0). out_code and out_injected are the FIFO head.
//  Pop when out_valid&&out_ready.
//  Latency: a word pushed in cycle N is visible on out_* in cycle N+1 at earliest. There is no bypass.
//  Simultaneous push+pop: level is unchanged and both pointers advance. Not possible when full, since in_ready=0.
//  Pointers wrap modulo DEPTH.
//  Head stability: while out_valid&&!out_ready, out_code, out_injected and out_valid hold.
//  Order: strictly FIFO.
//  word_cnt: +1 per push, wraps 2^CNT_W-1 -> 0.
//  Reset: level=0, pointers=0, out_valid=0, out_code=0, out_injected=0, word_cnt=0, inj_err=0, in_ready=0.
//  Reset mid-stream discards all buffered words. in_ready rises the cycle after sreset falls.
// STRUCTURE
//  Shared package hamming_11_7_pkg holds:
//   - constants DATA_W=7, CODE_W=11;
//   - parity position constants P1=0, P2=1, P4=3, P8=7;
//   - function ham_11_7_encode(d[6:0]) -> c[10:0], shared so the decoder and the bench use the identical map.
//  Sub-module hamming_enc_fifo: sync FIFO, WIDTH=12 (code+injected flag), DEPTH param, level out.
//  Top level: encode, inject, counters.
// TESTING
//  1. in_data=7'h00, 7'h7F, 7'h01, 7'h10, inj_en=0, out_ready=1 -> out_code 11'h000, 11'h7FF, 11'h007, 11'h181, one cycle after each push.
//  2. Exhaustive: all 128 data words -> out_code == ham_11_7_encode(d); the decoder model returns d with error flag 0.
//  3. in_data=7'h00, inj_en=1, inj_pos=3 -> out_code=11'h004, out_injected=1.
//     Then inj_pos=0 -> out_code=11'h000, out_injected=0, inj_err=1 and it stays 1.
//  4. DEPTH=4, out_ready=0, 5 words offered -> 4 accepted, in_ready=0, level=4.
//     Then out_ready=1 -> words drain in order and the 5th is accepted the cycle after the first pop.
//  5. Push and pop in the same cycle at level=2 -> level stays 2, word_cnt+1, order preserved.
//  6. sreset while level=3 -> next cycle level=0, out_valid=0, word_cnt=0.
//     Set word_cnt=16'hFFFF via pushes or force, then one push -> 0.

Source files
------------

// File: rtl/hamming_11_7_pkg.sv
// hamming_11_7_pkg: shared Hamming(11,7) constants and the codeword bit map
package hamming_11_7_pkg;

    localparam int DATA_W = 7;
    localparam int CODE_W = 11;
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int P4 = 3;
    localparam int P8 = 7;

    // Data bits fill the non-power-of-two positions; parity sits at positions 1,2,4,8 (1-based)
    function automatic logic [CODE_W-1:0] ham_11_7_encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        c = '0;
        c[2] = d[0];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[8] = d[4];
        c[9] = d[5];
        c[10] = d[6];
        c[P1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        c[P2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        c[P4] = d[1] ^ d[2] ^ d[3];
        c[P8] = d[4] ^ d[5] ^ d[6];
        return c;
    endfunction

endpackage

// File: rtl/hamming_enc_fifo.sv
// hamming_enc_fifo: synchronous FIFO holding encoded words, head read combinationally
module hamming_enc_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             sreset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;

    // Occupancy is unchanged on simultaneous push and pop
    always_comb level_d = level_q + LVL_W'(push) - LVL_W'(pop);

    // Storage is cleared on reset so an empty head reads as zero
    always_ff @(posedge clk) begin
        if (sreset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/hamming_encoder_11_7_stream.sv
// hamming_encoder_11_7_stream: streaming Hamming(11,7) encoder with error injection and output FIFO
module hamming_encoder_11_7_stream
    import hamming_11_7_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              sreset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              inj_en,
    input  logic [3:0]        inj_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_injected,
    output logic [LVL_W-1:0]  level,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              inj_err
);

    logic              push, pop, inj_ok;
    logic [CODE_W-1:0] flip, code;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              inj_err_q, inj_err_d;

    // Handshakes depend only on registered occupancy, never on out_ready combinationally into in_ready
    assign in_ready  = !sreset && (level != LVL_W'(DEPTH));
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Encode and optionally flip one 1-based codeword position
    always_comb begin
        inj_ok = inj_en && (inj_pos >= 4'd1) && (inj_pos <= 4'd11);
        flip   = inj_ok ? (CODE_W'(1) << (inj_pos - 4'd1)) : '0;
        code   = ham_11_7_encode(in_data) ^ flip;
    end

    // Next-state for the accepted-word counter and the sticky illegal-position flag
    always_comb begin
        word_cnt_d = push ? word_cnt_q + CNT_W'(1) : word_cnt_q;
        inj_err_d  = inj_err_q | (push && inj_en && !inj_ok);
    end

    // Status registers
    always_ff @(posedge clk) begin
        if (sreset) begin
            word_cnt_q <= '0;
            inj_err_q  <= 1'b0;
        end else begin
            word_cnt_q <= word_cnt_d;
            inj_err_q  <= inj_err_d;
        end
    end

    hamming_enc_fifo #(
        .WIDTH(CODE_W + 1),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .sreset(sreset),
        .push  (push),
        .wdata ({inj_ok, code}),
        .pop   (pop),
        .rdata ({out_injected, out_code}),
        .level (level)
    );

    assign word_cnt = word_cnt_q;
    assign inj_err  = inj_err_q;

endmodule
